// File: rtl/avalon_main_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_main_mem_responder
//  Brief    : Avalon-MM responder model for a 64-bit main data port.
//             Word-organised backing memory with byte-enable writes,
//             fixed-latency pipelined reads, waitrequest backpressure and
//             SLAVEERROR / DECODEERROR read responses.
//  Options  : AVALON_RESP_STALL_INJECT_EN - when defined, an LFSR injects
//             pseudo-random waitrequest stalls (about 25 % of cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module avalon_main_mem_responder #(
    parameter int unsigned DepthWords  = 4096,          // power of two, >= 2
    parameter logic [31:0] BaseAddr    = 32'h0000_0000, // 8-byte aligned
    parameter int unsigned ReadLatency = 2,             // 1..8
    parameter logic [15:0] StallSeed   = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] avs_address,
    input  logic [7:0]  avs_byteenable,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [63:0] avs_writedata,
    output logic        avs_waitrequest,
    output logic [63:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [1:0]  avs_response
);

    localparam int unsigned c_idx_w       = $clog2(DepthWords);
    localparam logic [1:0]  c_resp_okay   = 2'b00;
    localparam logic [1:0]  c_resp_slverr = 2'b10;
    localparam logic [1:0]  c_resp_decerr = 2'b11;

    // ------------------------------------------------------------------------
    // Ready / stall generation
    // ------------------------------------------------------------------------
    logic ready_q;
    logic ready_d;
    logic stall;

    // The port becomes ready on the first edge after reset is released.
    always_comb begin
        ready_d = 1'b1;
    end

    // Ready flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

`ifdef AVALON_RESP_STALL_INJECT_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci LFSR, taps 16/14/13/11, advanced every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= StallSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Roughly one cycle in four is stalled; depends only on state, never on
    // the request lines.
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    localparam logic [15:0] c_unused_stall_seed = StallSeed;
    assign stall = 1'b0;
`endif

    assign avs_waitrequest = ~ready_q | stall;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic [28:0]        word_off;
    logic [c_idx_w-1:0] word_idx;
    logic               in_range;
    logic               unused_addr_lsbs;

    // Word offset is computed on the word-aligned part of the address, so
    // the byte-offset bits never participate.
    assign word_off         = avs_address[31:3] - BaseAddr[31:3];
    assign word_idx         = word_off[c_idx_w-1:0];
    assign in_range         = (avs_address >= BaseAddr) &&
                              ({3'b000, word_off} < DepthWords);
    assign unused_addr_lsbs = ^avs_address[2:0];

    // ------------------------------------------------------------------------
    // Acceptance
    // ------------------------------------------------------------------------
    logic accept;
    logic rd_accept;
    logic wr_commit;

    assign accept    = (avs_read | avs_write) & ~avs_waitrequest;
    assign rd_accept = accept & avs_read;
    // A simultaneous read+write is answered as an error and never writes.
    assign wr_commit = accept & avs_write & ~avs_read & in_range;

    // ------------------------------------------------------------------------
    // Backing memory (contents are deliberately not reset)
    // ------------------------------------------------------------------------
    logic [63:0] mem_q [DepthWords];

    // Byte-lane write of an accepted, in-range write.
    always_ff @(posedge clk_i) begin
        if (wr_commit) begin
            for (int b = 0; b < 8; b++) begin
                if (avs_byteenable[b]) begin
                    mem_q[word_idx][8*b +: 8] <= avs_writedata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read response pipeline
    // ------------------------------------------------------------------------
    logic        new_valid;
    logic [63:0] new_data;
    logic [1:0]  new_resp;

    logic [ReadLatency-1:0] pipe_valid_q;
    logic [ReadLatency-1:0] pipe_valid_d;
    logic [63:0]            pipe_data_q [ReadLatency];
    logic [63:0]            pipe_data_d [ReadLatency];
    logic [1:0]             pipe_resp_q [ReadLatency];
    logic [1:0]             pipe_resp_d [ReadLatency];

    // Build the entry for a read accepted this cycle. Empty slots carry zero
    // data and OKAY so the outputs idle at zero between responses.
    always_comb begin
        new_valid = rd_accept;
        new_data  = 64'h0;
        new_resp  = c_resp_okay;
        if (rd_accept) begin
            if (avs_write) begin
                new_resp = c_resp_slverr;
            end else if (!in_range) begin
                new_resp = c_resp_decerr;
            end else begin
                new_data = mem_q[word_idx];
            end
        end
    end

    // Shift the pipeline by one stage per cycle; stage 0 takes the new entry.
    always_comb begin
        pipe_valid_d    = pipe_valid_q;
        pipe_data_d     = pipe_data_q;
        pipe_resp_d     = pipe_resp_q;
        pipe_valid_d[0] = new_valid;
        pipe_data_d[0]  = new_data;
        pipe_resp_d[0]  = new_resp;
        for (int s = 1; s < ReadLatency; s++) begin
            pipe_valid_d[s] = pipe_valid_q[s-1];
            pipe_data_d[s]  = pipe_data_q[s-1];
            pipe_resp_d[s]  = pipe_resp_q[s-1];
        end
    end

    // Pipeline registers; reset flushes every in-flight read at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid_q <= '0;
            for (int s = 0; s < ReadLatency; s++) begin
                pipe_data_q[s] <= 64'h0;
                pipe_resp_q[s] <= c_resp_okay;
            end
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            pipe_resp_q  <= pipe_resp_d;
        end
    end

    assign avs_readdatavalid = pipe_valid_q[ReadLatency-1];
    assign avs_readdata      = pipe_data_q[ReadLatency-1];
    assign avs_response      = pipe_resp_q[ReadLatency-1];

endmodule
`default_nettype wire

// File: tb/tb_avalon_main_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avalon_main_mem_responder
//  Brief    : Self-checking bench for avalon_main_mem_responder (default
//             build). A transaction-level memory model predicts every
//             response; directed literal checks pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_main_mem_responder;

    localparam int unsigned c_DEPTH = 4096;
    localparam int unsigned c_LAT   = 2;
    localparam logic [31:0] c_BASE  = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] avs_address = '0;
    logic [7:0]  avs_byteenable = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [63:0] avs_writedata = '0;
    logic        avs_waitrequest;
    logic [63:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [1:0]  avs_response;

    avalon_main_mem_responder #(
        .DepthWords  (c_DEPTH),
        .BaseAddr    (c_BASE),
        .ReadLatency (c_LAT),
        .StallSeed   (16'hACE1)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .avs_address       (avs_address),
        .avs_byteenable    (avs_byteenable),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_response      (avs_response)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------------
    typedef struct { logic [63:0] d; logic [1:0] r; int due; } exp_t;
    typedef struct { logic [63:0] d; logic [1:0] r; int cap; } obs_t;

    exp_t        expq[$];
    obs_t        obsq[$];
    logic [63:0] mmem [int];
    int          edge_n     = 0;
    bit          m_ready    = 1'b0;
    bit          m_acc      = 1'b0;
    int          m_acc_edge = 0;

    // At each edge: decide acceptance from the model's own readiness, update
    // the model memory, and schedule the response. A read accepted at edge n
    // is visible after edge n+LAT-1 and captured by the initiator at n+LAT.
    always @(posedge clk_i) begin : model
        bit          inr;
        int          widx;
        logic [63:0] w;
        exp_t        e;
        edge_n++;
        m_acc = 1'b0;
        if (rst_ni) begin
            if ((avs_read || avs_write) && m_ready) begin
                m_acc      = 1'b1;
                m_acc_edge = edge_n;
                inr  = (avs_address >= c_BASE) && (((avs_address - c_BASE) >> 3) < c_DEPTH);
                widx = int'((avs_address - c_BASE) >> 3);
                e.due = edge_n + int'(c_LAT) - 1;
                e.d   = 64'h0;
                e.r   = 2'b00;
                if (avs_read && avs_write) begin
                    e.r = 2'b10;
                    expq.push_back(e);
                end else if (avs_read) begin
                    if (!inr) e.r = 2'b11;
                    else if (mmem.exists(widx)) e.d = mmem[widx];
                    expq.push_back(e);
                end else if (inr && avs_byteenable != 8'h00) begin
                    w = mmem.exists(widx) ? mmem[widx] : 64'h0;
                    for (int b = 0; b < 8; b++)
                        if (avs_byteenable[b]) w[8*b +: 8] = avs_writedata[8*b +: 8];
                    mmem[widx] = w;
                end
            end
            m_ready = 1'b1;
        end else begin
            m_ready = 1'b0;
        end
    end

    // Reset discards every outstanding response immediately.
    always @(negedge rst_ni) begin
        expq.delete();
        m_ready = 1'b0;
    end

    // Compare DUT outputs with the model every cycle, mid-cycle.
    always @(negedge clk_i) begin : compare
        bit   ev;
        exp_t h;
        obs_t o;
        ev = (expq.size() > 0) && (expq[0].due == edge_n);
        chk("waitrequest", 64'(avs_waitrequest), 64'(!m_ready));
        chk("readdatavalid", 64'(avs_readdatavalid), 64'(ev));
        if (ev) begin
            h = expq.pop_front();
            chk("readdata", avs_readdata, h.d);
            chk("response", 64'(avs_response), 64'(h.r));
        end else begin
            chk("response_idle", 64'(avs_response), 64'h0);
        end
        if (!rst_ni) chk("readdata_in_reset", avs_readdata, 64'h0);
        if (avs_readdatavalid) begin
            o.d = avs_readdata;
            o.r = avs_response;
            o.cap = edge_n + 1;
            obsq.push_back(o);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after a rising edge)
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic idle();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    // Present a request and hold it until the model accepts it.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [7:0] be, input logic [63:0] wd);
        avs_read       = rd;
        avs_write      = wr;
        avs_address    = a;
        avs_byteenable = be;
        avs_writedata  = wd;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_i);
            #2;
            if (m_acc) return;
        end
        vectors++;
        fails++;
        $display("FAIL issue_timeout: request at 0x%0h not accepted, expected within 16 cycles", a);
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [7:0] be, input logic [63:0] d);
        issue(1'b0, 1'b1, a, be, d);
        idle();
    endtask

    task automatic rd_word(input logic [31:0] a);
        issue(1'b1, 1'b0, a, 8'h00, 64'h0);
    endtask

    // Exactly one response, with literal data/response, captured LAT edges
    // after the acceptance edge.
    task automatic expect_one(input string nm, input logic [63:0] d, input logic [1:0] r, input int acc);
        idle();
        tick(4);
        chk({nm, "_count"}, 64'(obsq.size()), 64'd1);
        if (obsq.size() > 0) begin
            chk({nm, "_data"}, obsq[0].d, d);
            chk({nm, "_resp"}, 64'(obsq[0].r), 64'(r));
            chk({nm, "_latency"}, 64'(obsq[0].cap - acc), 64'd2);
        end
        obsq.delete();
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin : stim
        int acc;
        tick(3);
        rst_ni = 1'b1;

        // Full write then read-back.
        wr_word(32'h10, 8'hFF, 64'h0123_4567_89AB_CDEF);
        obsq.delete();
        rd_word(32'h10);
        acc = m_acc_edge;
        expect_one("full_rw", 64'h0123_4567_89AB_CDEF, 2'b00, acc);

        // Partial write of the low four bytes.
        wr_word(32'h10, 8'h0F, 64'hFFFF_FFFF_1111_2222);
        rd_word(32'h10);
        acc = m_acc_edge;
        expect_one("partial", 64'h0123_4567_1111_2222, 2'b00, acc);

        // Back-to-back reads of four consecutive words.
        wr_word(32'h00, 8'hFF, 64'h1111_1111_1111_1111);
        wr_word(32'h08, 8'hFF, 64'h2222_2222_2222_2222);
        wr_word(32'h18, 8'hFF, 64'h4444_4444_4444_4444);
        obsq.delete();
        rd_word(32'h00);
        rd_word(32'h08);
        rd_word(32'h10);
        rd_word(32'h18);
        idle();
        tick(4);
        chk("b2b_count", 64'(obsq.size()), 64'd4);
        if (obsq.size() == 4) begin
            chk("b2b_d0", obsq[0].d, 64'h1111_1111_1111_1111);
            chk("b2b_d1", obsq[1].d, 64'h2222_2222_2222_2222);
            chk("b2b_d2", obsq[2].d, 64'h0123_4567_1111_2222);
            chk("b2b_d3", obsq[3].d, 64'h4444_4444_4444_4444);
            for (int i = 1; i < 4; i++)
                chk("b2b_consecutive", 64'(obsq[i].cap - obsq[i-1].cap), 64'd1);
        end
        obsq.delete();

        // Last in-range word, first out-of-range word.
        wr_word(32'h7FF8, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
        rd_word(32'h7FF8);
        acc = m_acc_edge;
        expect_one("last_word", 64'hDEAD_BEEF_CAFE_F00D, 2'b00, acc);
        rd_word(32'h8000);
        acc = m_acc_edge;
        expect_one("oor_read", 64'h0, 2'b11, acc);
        wr_word(32'h8000, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0);
        tick(4);
        chk("oor_write_no_resp", 64'(obsq.size()), 64'd0);
        rd_word(32'h00);
        acc = m_acc_edge;
        expect_one("oor_no_alias", 64'h1111_1111_1111_1111, 2'b00, acc);

        // Simultaneous read and write.
        wr_word(32'h20, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5);
        issue(1'b1, 1'b1, 32'h20, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A);
        acc = m_acc_edge;
        expect_one("rw_both", 64'h0, 2'b10, acc);
        rd_word(32'h20);
        acc = m_acc_edge;
        expect_one("rw_no_write", 64'hA5A5_A5A5_A5A5_A5A5, 2'b00, acc);

        // Reset with two reads in flight.
        obsq.delete();
        rd_word(32'h00);
        rd_word(32'h08);
        avs_read = 1'b0;
        rst_ni   = 1'b0;
        tick(3);
        chk("reset_flush", 64'(obsq.size()), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("wait_after_release", 64'(avs_waitrequest), 64'd1);
        @(negedge clk_i);
        chk("ready_after_edge", 64'(avs_waitrequest), 64'd0);
        tick(1);
        rd_word(32'h10);
        acc = m_acc_edge;
        expect_one("mem_kept", 64'h0123_4567_1111_2222, 2'b00, acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/avalon_main_mem_responder.md
Name: avalon_main_mem_responder

Overview:
- Avalon-MM responder (slave) model for the 64-bit main data port driven by the ibex Avalon wrapper (avm_main_* signals).
- Provides word-organised backing memory with byte-enable writes, pipelined fixed-latency reads, waitrequest backpressure and error responses.
- Used in simulation and FPGA test harnesses as the far end of the core's data bus.

Parameters:
- DepthWords, 4096, number of 64-bit words in the memory (power of two).
- BaseAddr, 32'h0000_0000, byte address of word 0; must be 8-byte aligned.
- ReadLatency, 2, cycles from read acceptance to readdatavalid; legal range 1..8.
- StallSeed, 16'hACE1, LFSR seed for stall injection; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- avs_address  in  32  byte address; bits [2:0] ignored.
- avs_byteenable  in  8  byte lane enables for writes; ignored for reads.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  64  write data.
- avs_waitrequest  out  1  high = request not accepted this cycle.
- avs_readdata  out  64  read data, valid with avs_readdatavalid.
- avs_readdatavalid  out  1  one-cycle pulse per accepted read.
- avs_response  out  2  00 OKAY, 10 SLAVEERROR, 11 DECODEERROR; valid with avs_readdatavalid, else 00.

Behaviour:
- Clock/reset: one clock, clk_i; reset is asynchronous and active-low on rst_ni.
- Reset values: avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, avs_response=00, all pipeline valids=0. Memory contents are not reset.
- ready_q resets to 0 and sets on the first rising edge after rst_ni deasserts. avs_waitrequest = ~ready_q | stall; stall is 0 unless the optional feature is compiled in.
- Acceptance: a request is accepted on a rising edge where (avs_read|avs_write) & ~avs_waitrequest. While waitrequest is high, the initiator holds its request stable. Waitrequest never depends combinationally on avs_read or avs_write.
- Decode: word_idx = (avs_address - BaseAddr) >> 3. In range iff avs_address >= BaseAddr and word_idx < DepthWords.
- Accepted write, in range: for each i with avs_byteenable[i]=1, mem[word_idx][8i+7:8i] <= avs_writedata[8i+7:8i] at the acceptance edge.
- Accepted write, out of range, or byteenable=0: no state change.
- Writes produce no response: no readdatavalid, no response field.
- Accepted read: samples mem[word_idx] at the acceptance edge. Data and response enter the ReadLatency-deep valid/data/response shift pipeline.
- Read output timing: avs_readdatavalid pulses exactly ReadLatency cycles after the acceptance edge; readdata and response are registered outputs.
- Read responses: out-of-range read returns readdata=0, response=11.
- Read-after-write: a read accepted on the cycle after a write to the same word returns the new data. A write and a read accepted on the same edge cannot occur (see next bullet).
- Simultaneous avs_read & avs_write accepted: write suppressed; a read response with readdata=0, response=10 is issued after ReadLatency.
- Throughput: one read per cycle at full rate; up to ReadLatency reads outstanding, responses returned in order. Readdatavalid cannot be backpressured.
- Reset mid-operation: the pipeline is flushed immediately; no readdatavalid for reads in flight. Memory writes already accepted remain.

Optional Feature:
- Macro: AVALON_RESP_STALL_INJECT_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to StallSeed and advanced every cycle, drives stall = lfsr[1:0]==2'b00, giving about 25% waitrequest cycles. Stall must not change the data outcome of any request.
- Undefined: stall is tied to 0 and the LFSR logic is absent.

Test Plan:
- Reset release, then write addr 0x10, be=8'hFF, data 64'h0123_4567_89AB_CDEF; read 0x10 -> readdatavalid exactly 2 cycles after acceptance, data 64'h0123_4567_89AB_CDEF, response 00.
- Partial write be=8'h0F, data 64'hFFFF_FFFF_1111_2222 to 0x10; read 0x10 -> 64'h0123_4567_1111_2222.
- Back-to-back reads of 0x0, 0x8, 0x10, 0x18 on consecutive cycles -> four consecutive readdatavalid pulses, in order, each response 00.
- Read of BaseAddr + DepthWords*8 -> readdata 0, response 11. Write to the same address -> no memory change and no readdatavalid.
- Read and write both high at 0x20 -> response 10 and mem[4] unchanged. Also assert rst_ni low with two reads in flight -> no readdatavalid, and waitrequest is high until the first edge after release.
- With AVALON_RESP_STALL_INJECT_EN: 1000 random reads and writes checked against a scoreboard -> zero mismatches, waitrequest duty 20-30%, requests held stable through every stall.
